// File: rtl/gpsreceiver2_capture.sv
// Packs 2-bit GPS front-end samples into bytes and writes them to the receive buffer RAM.
// Optional half-buffer pulse output enabled by defining GPSRECEIVER2_CAPTURE_HALF_EN.
module gpsreceiver2_capture (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [1:0]  sample_i,
    input  logic        sample_stb,
    input  logic        start,
    input  logic        stop,
    input  logic        continuous,
    input  logic [10:0] length,
    output logic [7:0]  rxb0_dat,
    output logic [10:0] rxb0_adr,
    output logic        rxb0_we,
    output logic        busy,
    output logic        done,
    output logic        wrap,
    output logic [11:0] count,
`ifdef GPSRECEIVER2_CAPTURE_HALF_EN
    output logic        half,
`endif
    output logic        dbg_state
);

    // sample_stb is a valid-only qualifier with no ready: the block accepts every strobed
    // sample in CAPTURE and drops it otherwise; rxb0_we is a one-cycle write with no back-pressure.
    typedef enum logic {IDLE = 1'b0, CAPTURE = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [11:0] len_q, len_d;
    logic        cont_q, cont_d;
    logic [10:0] adr_q, adr_d;
    logic [11:0] cnt_q, cnt_d;
    logic [1:0]  pack_q, pack_d;
    logic [5:0]  shreg_q, shreg_d;
    logic        we_q, we_d;
    logic [7:0]  dat_q, dat_d;
    logic [10:0] wadr_q, wadr_d;
    logic        done_q, done_d;
    logic        wrap_q, wrap_d;
    logic        fourth;
    logic        last;
    logic [7:0]  byte_full;
`ifdef GPSRECEIVER2_CAPTURE_HALF_EN
    logic        half_q, half_d;
    logic [11:0] half_mark;
`endif

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        cont_d    = cont_q;
        adr_d     = adr_q;
        cnt_d     = cnt_q;
        pack_d    = pack_q;
        shreg_d   = shreg_q;
        we_d      = 1'b0;
        dat_d     = dat_q;
        wadr_d    = wadr_q;
        done_d    = 1'b0;
        wrap_d    = 1'b0;
        byte_full = {shreg_q, sample_i};
        fourth    = (state_q == CAPTURE) && sample_stb && (pack_q == 2'd3);
        last      = ({1'b0, adr_q} == (len_q - 12'd1));
`ifdef GPSRECEIVER2_CAPTURE_HALF_EN
        half_d    = 1'b0;
        half_mark = (len_q >> 1) - 12'd1;
`endif
        case (state_q)
            IDLE: begin
                // stop wins over a coincident start
                if (start && !stop) begin
                    state_d = CAPTURE;
                    len_d   = (length == 11'd0) ? 12'd2048 : {1'b0, length};
                    cont_d  = continuous;
                    adr_d   = 11'd0;
                    cnt_d   = 12'd0;
                    pack_d  = 2'd0;
                    shreg_d = 6'd0;
                end
            end
            CAPTURE: begin
                if (sample_stb) begin
                    shreg_d = byte_full[5:0];
                    pack_d  = pack_q + 2'd1;
                end
                if (fourth) begin
                    we_d   = 1'b1;
                    dat_d  = byte_full;
                    wadr_d = adr_q;
                    if (cnt_q != 12'd2048) cnt_d = cnt_q + 12'd1;
                    adr_d  = adr_q + 11'd1;
                    if (last) begin
                        done_d = !cont_q && !stop;
                        wrap_d = cont_q;
                        if (cont_q) adr_d = 11'd0;
                    end
`ifdef GPSRECEIVER2_CAPTURE_HALF_EN
                    half_d = (len_q != 12'd1) && ({1'b0, adr_q} == half_mark);
`endif
                end
                // done_q marks the final single-shot write cycle; leave right after it
                if (stop || done_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
            len_q   <= 12'd0;
            cont_q  <= 1'b0;
            adr_q   <= 11'd0;
            cnt_q   <= 12'd0;
            pack_q  <= 2'd0;
            shreg_q <= 6'd0;
            we_q    <= 1'b0;
            dat_q   <= 8'd0;
            wadr_q  <= 11'd0;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cont_q  <= cont_d;
            adr_q   <= adr_d;
            cnt_q   <= cnt_d;
            pack_q  <= pack_d;
            shreg_q <= shreg_d;
            we_q    <= we_d;
            dat_q   <= dat_d;
            wadr_q  <= wadr_d;
            done_q  <= done_d;
            wrap_q  <= wrap_d;
        end
    end

`ifdef GPSRECEIVER2_CAPTURE_HALF_EN
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) half_q <= 1'b0;
        else            half_q <= half_d;
    end
    assign half = half_q;
`endif

    assign rxb0_we   = we_q;
    assign rxb0_dat  = dat_q;
    assign rxb0_adr  = wadr_q;
    assign done      = done_q;
    assign wrap      = wrap_q;
    assign count     = cnt_q;
    assign busy      = (state_q == CAPTURE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_gpsreceiver2_capture.sv
// Self-checking bench for gpsreceiver2_capture: a byte-level reference model feeds an
// expected-write queue that a negedge monitor drains as rxb0_we pulses appear.
module tb_gpsreceiver2_capture;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [1:0]  sample_i = 2'd0;
    logic        sample_stb = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        continuous = 1'b0;
    logic [10:0] length = 11'd0;
    logic [7:0]  rxb0_dat;
    logic [10:0] rxb0_adr;
    logic        rxb0_we;
    logic        busy;
    logic        done;
    logic        wrap;
    logic [11:0] count;
    logic        dbg_state;
    logic        half_w;

    gpsreceiver2_capture dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .sample_i   (sample_i),
        .sample_stb (sample_stb),
        .start      (start),
        .stop       (stop),
        .continuous (continuous),
        .length     (length),
        .rxb0_dat   (rxb0_dat),
        .rxb0_adr   (rxb0_adr),
        .rxb0_we    (rxb0_we),
        .busy       (busy),
        .done       (done),
        .wrap       (wrap),
        .count      (count),
`ifdef GPSRECEIVER2_CAPTURE_HALF_EN
        .half       (half_w),
`endif
        .dbg_state  (dbg_state)
    );
`ifndef GPSRECEIVER2_CAPTURE_HALF_EN
    assign half_w = 1'b0;
`endif

    // clock/reset block
    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_fail = 0;
    int n_writes = 0;
    int done_seen = 0;
    int wrap_seen = 0;
    int half_seen = 0;

    // scoreboard entry: {half, done, wrap, adr[10:0], dat[7:0]}
    logic [21:0] exp_q[$];

    // reference model state
    bit          m_active = 0;
    int          m_len = 0;
    bit          m_cont = 0;
    int          m_adr = 0;
    int          m_pack = 0;
    logic [7:0]  m_byte = 8'd0;

    // monitor / scoreboard drain
    logic [21:0] obs;
    logic [21:0] expv;
    logic        prev_we = 1'b0;
    always @(negedge sys_clk) begin
        obs = {half_w, done, wrap, rxb0_adr, rxb0_dat};
        if (rxb0_we) begin
            n_writes++;
            if (done) done_seen++;
            if (wrap) wrap_seen++;
            if (half_w) half_seen++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write got=%h expected=none", obs);
            end else begin
                expv = exp_q.pop_front();
                if (obs !== expv) begin
                    n_fail++;
                    $display("FAIL write_entry got={h%b d%b w%b adr%0d dat%h} expected={h%b d%b w%b adr%0d dat%h}",
                             obs[21], obs[20], obs[19], obs[18:8], obs[7:0],
                             expv[21], expv[20], expv[19], expv[18:8], expv[7:0]);
                end
            end
            if (prev_we) begin
                n_checks++;
                n_fail++;
                $display("FAIL we_back_to_back got=1 expected=0");
            end
        end else if (done || wrap || half_w) begin
            n_checks++;
            n_fail++;
            $display("FAIL pulse_without_write got=%b%b%b expected=000", done, wrap, half_w);
        end
        prev_we = rxb0_we;
    end

    // driver tasks
    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_start(input int len, input bit cont);
        length = 11'(len);
        continuous = cont;
        start = 1'b1;
        tick();
        start = 1'b0;
        m_active = 1;
        m_len = (len == 0) ? 2048 : len;
        m_cont = cont;
        m_adr = 0;
        m_pack = 0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        m_active = 0;
    endtask

    task automatic strobe(input logic [1:0] s);
        bit last;
        bit h;
        sample_i = s;
        sample_stb = 1'b1;
        if (m_active) begin
            m_byte = {m_byte[5:0], s};
            m_pack++;
            if (m_pack == 4) begin
                m_pack = 0;
                last = (m_adr == m_len - 1);
                h = (m_len != 1) && (m_adr == m_len / 2 - 1);
`ifndef GPSRECEIVER2_CAPTURE_HALF_EN
                h = 1'b0;
`endif
                exp_q.push_back({h, last && !m_cont, last && m_cont, 11'(m_adr), m_byte});
                if (last) begin
                    if (m_cont) m_adr = 0;
                    else m_active = 0;
                end else begin
                    m_adr++;
                end
            end
        end
        tick();
        sample_stb = 1'b0;
    endtask

    task automatic settle_and_check_queue(input string name);
        tick();
        tick();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_pending_writes got=%0d expected=0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic clear_counts();
        n_writes = 0;
        done_seen = 0;
        wrap_seen = 0;
        half_seen = 0;
    endtask

    // scenarios
    task automatic test_reset();
        sys_rst_n = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({busy, done, wrap, rxb0_we, half_w, dbg_state} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags got=%b expected=000000", {busy, done, wrap, rxb0_we, half_w, dbg_state});
        end
        n_checks++;
        if ({rxb0_dat, rxb0_adr, count} !== 31'd0) begin
            n_fail++;
            $display("FAIL reset_values got=dat%h adr%0d cnt%0d expected=0", rxb0_dat, rxb0_adr, count);
        end
        sys_rst_n = 1'b1;
        tick();
        // strobes in IDLE must not write
        clear_counts();
        for (int i = 0; i < 8; i++) strobe(2'(i));
        settle_and_check_queue("idle");
        n_checks++;
        if (n_writes != 0) begin
            n_fail++;
            $display("FAIL idle_writes got=%0d expected=0", n_writes);
        end
    endtask

    task automatic test_single_shot();
        clear_counts();
        do_start(4, 0);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_busy got=%b expected=1", busy);
        end
        for (int i = 0; i < 16; i++) strobe(2'b10);
        // write cycle of the 4th byte: done high now, busy must drop on the next edge
        n_checks++;
        if ({rxb0_we, done} !== 2'b11) begin
            n_fail++;
            $display("FAIL single_last_write got=%b expected=11", {rxb0_we, done});
        end
        tick();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_busy_after got=%b expected=0", busy);
        end
        n_checks++;
        if (count !== 12'd4) begin
            n_fail++;
            $display("FAIL single_count got=%0d expected=4", count);
        end
        settle_and_check_queue("single");
        n_checks++;
        if (n_writes != 4 || done_seen != 1) begin
            n_fail++;
            $display("FAIL single_totals got=w%0d d%0d expected=w4 d1", n_writes, done_seen);
        end
    endtask

    task automatic test_packing();
        clear_counts();
        do_start(8, 0);
        strobe(2'd3);
        strobe(2'd0);
        strobe(2'd1);
        strobe(2'd2);
        n_checks++;
        if ({rxb0_we, rxb0_dat, rxb0_adr} !== {1'b1, 8'hC6, 11'd0}) begin
            n_fail++;
            $display("FAIL packing_latency got=we%b dat%h adr%0d expected=we1 datc6 adr0", rxb0_we, rxb0_dat, rxb0_adr);
        end
        do_stop();
        settle_and_check_queue("packing");
    endtask

    task automatic test_continuous();
        clear_counts();
        do_start(2, 1);
        for (int i = 0; i < 24; i++) strobe(2'($urandom_range(0, 3)));
        tick();
        n_checks++;
        if (busy !== 1'b1 || count !== 12'd6) begin
            n_fail++;
            $display("FAIL cont_state got=busy%b cnt%0d expected=busy1 cnt6", busy, count);
        end
        do_stop();
        settle_and_check_queue("cont");
        n_checks++;
        if (wrap_seen != 3 || done_seen != 0 || n_writes != 6) begin
            n_fail++;
            $display("FAIL cont_totals got=w%0d wr%0d d%0d expected=w6 wr3 d0", n_writes, wrap_seen, done_seen);
        end
    endtask

    task automatic test_abort();
        clear_counts();
        do_start(8, 0);
        strobe(2'b01);
        strobe(2'b10);
        // start during CAPTURE is ignored
        length = 11'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) strobe(2'b11);
        do_stop();
        n_checks++;
        if (busy !== 1'b0 || dbg_state !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle got=busy%b st%b expected=busy0 st0", busy, dbg_state);
        end
        for (int i = 0; i < 8; i++) strobe(2'b01);
        settle_and_check_queue("abort");
        n_checks++;
        if (n_writes != 1 || done_seen != 0 || count !== 12'd1) begin
            n_fail++;
            $display("FAIL abort_totals got=w%0d d%0d cnt%0d expected=w1 d0 cnt1", n_writes, done_seen, count);
        end
    endtask

    task automatic test_start_edges();
        clear_counts();
        // start and stop together in IDLE: stay idle
        length = 11'd4;
        start = 1'b1;
        stop = 1'b1;
        tick();
        start = 1'b0;
        stop = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL start_stop_busy got=%b expected=0", busy);
        end
        for (int i = 0; i < 4; i++) strobe(2'b11);
        // strobe coincident with start is not captured; L=1 never pulses half
        length = 11'd1;
        continuous = 1'b0;
        sample_i = 2'b11;
        sample_stb = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        sample_stb = 1'b0;
        m_active = 1;
        m_len = 1;
        m_cont = 0;
        m_adr = 0;
        m_pack = 0;
        for (int i = 0; i < 4; i++) strobe(2'b00);
        settle_and_check_queue("start_edges");
        n_checks++;
        if (n_writes != 1 || done_seen != 1 || half_seen != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL start_edges_totals got=w%0d d%0d h%0d busy%b expected=w1 d1 h0 busy0",
                     n_writes, done_seen, half_seen, busy);
        end
    endtask

    task automatic test_length0();
        int exp_half;
        clear_counts();
        do_start(0, 0);
        for (int i = 0; i < 8192; i++) strobe(2'($urandom_range(0, 3)));
        settle_and_check_queue("len0");
`ifdef GPSRECEIVER2_CAPTURE_HALF_EN
        exp_half = 1;
`else
        exp_half = 0;
`endif
        n_checks++;
        if (n_writes != 2048 || done_seen != 1 || half_seen != exp_half || count !== 12'd2048) begin
            n_fail++;
            $display("FAIL len0_totals got=w%0d d%0d h%0d cnt%0d expected=w2048 d1 h%0d cnt2048",
                     n_writes, done_seen, half_seen, count, exp_half);
        end
    endtask

    task automatic test_reset_mid();
        clear_counts();
        do_start(8, 0);
        for (int i = 0; i < 5; i++) strobe(2'b10);
        tick();
        n_checks++;
        if (busy !== 1'b1 || count !== 12'd1 || rxb0_dat !== 8'hAA) begin
            n_fail++;
            $display("FAIL mid_before got=busy%b cnt%0d dat%h expected=busy1 cnt1 dataa", busy, count, rxb0_dat);
        end
        #2;
        sys_rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, wrap, rxb0_we, dbg_state, rxb0_dat, rxb0_adr, count} !== 36'd0) begin
            n_fail++;
            $display("FAIL mid_async_reset got=busy%b cnt%0d dat%h adr%0d expected=0", busy, count, rxb0_dat, rxb0_adr);
        end
        m_active = 0;
        tick();
        sys_rst_n = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) strobe(2'b10);
        settle_and_check_queue("mid");
        n_checks++;
        if (busy !== 1'b0 || n_writes != 1 || done_seen != 0) begin
            n_fail++;
            $display("FAIL mid_after got=busy%b w%0d d%0d expected=busy0 w1 d0", busy, n_writes, done_seen);
        end
    endtask

    initial begin
        test_reset();
        test_single_shot();
        test_packing();
        test_continuous();
        test_abort();
        test_start_edges();
        test_length0();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
